// File: rtl/subtractor_8b_seq.sv
// Bit-serial subtractor: computes in0 - in1 - bin one bit per cycle, LSB first,
// with val/rdy handshakes on both the request and the response side.
module subtractor_8b_seq #(
    parameter int NBITS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_val,
    output logic             req_rdy,
    input  logic [NBITS-1:0] req_in0,
    input  logic [NBITS-1:0] req_in1,
    input  logic             req_bin,
    output logic             resp_val,
    input  logic             resp_rdy,
    output logic [NBITS-1:0] resp_diff,
    output logic             resp_bout
);

    localparam int CW = $clog2(NBITS + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Full-subtractor difference bit.
    function automatic logic sub_diff(input logic a, input logic b, input logic br);
        return a ^ b ^ br;
    endfunction

    // Full-subtractor borrow-out.
    function automatic logic sub_borrow(input logic a, input logic b, input logic br);
        return (~a & b) | (~(a ^ b) & br);
    endfunction

    state_t           state_r;
    state_t           next_state_s;
    logic [NBITS-1:0] a_r;
    logic [NBITS-1:0] b_r;
    logic [NBITS-1:0] d_r;
    logic             br_r;
    logic [CW-1:0]    cnt_r;
    logic [NBITS-1:0] resp_diff_r;
    logic             resp_bout_r;
    logic             diff_bit_s;
    logic             borrow_next_s;
    logic             last_bit_s;
    logic             accept_s;
    logic             consume_s;

    assign diff_bit_s    = sub_diff(a_r[0], b_r[0], br_r);
    assign borrow_next_s = sub_borrow(a_r[0], b_r[0], br_r);
    assign last_bit_s    = (cnt_r == CW'(NBITS - 1));
    assign accept_s      = (state_r == ST_IDLE) && req_val;
    assign consume_s     = (state_r == ST_DONE) && resp_rdy;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_state_s = ST_CALC;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (last_bit_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_CALC;
                end
            end
            ST_DONE: begin
                if (consume_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Operand shift registers, borrow flop, bit counter and result registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            a_r         <= '0;
            b_r         <= '0;
            d_r         <= '0;
            br_r        <= 1'b0;
            cnt_r       <= '0;
            resp_diff_r <= '0;
            resp_bout_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        a_r   <= req_in0;
                        b_r   <= req_in1;
                        br_r  <= req_bin;
                        cnt_r <= '0;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_CALC: begin
                    a_r   <= {1'b0, a_r[NBITS-1:1]};
                    b_r   <= {1'b0, b_r[NBITS-1:1]};
                    d_r   <= {diff_bit_s, d_r[NBITS-1:1]};
                    br_r  <= borrow_next_s;
                    cnt_r <= cnt_r + CW'(1);
                    // The final bit is merged in directly so the result lands on the DONE edge.
                    if (last_bit_s) begin
                        resp_diff_r <= {diff_bit_s, d_r[NBITS-1:1]};
                        resp_bout_r <= borrow_next_s;
                    end else begin
                        resp_bout_r <= resp_bout_r;
                    end
                end
                ST_DONE: begin
                    cnt_r <= cnt_r;
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

    assign req_rdy   = (state_r == ST_IDLE);
    assign resp_val  = (state_r == ST_DONE);
    assign resp_diff = resp_diff_r;
    assign resp_bout = resp_bout_r;

endmodule

// File: tb/tb_subtractor_8b_seq.sv
// Directed and random checks for subtractor_8b_seq: results, latency,
// backpressure hold, handshake timing and mid-operation reset.
module tb_subtractor_8b_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_val;
    logic       req_rdy;
    logic [7:0] req_in0;
    logic [7:0] req_in1;
    logic       req_bin;
    logic       resp_val;
    logic       resp_rdy;
    logic [7:0] resp_diff;
    logic       resp_bout;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int fail_cnt = 0;

    always #5 clk = ~clk;

    subtractor_8b_seq dut (
        .clk       (clk),
        .reset     (reset),
        .req_val   (req_val),
        .req_rdy   (req_rdy),
        .req_in0   (req_in0),
        .req_in1   (req_in1),
        .req_bin   (req_bin),
        .resp_val  (resp_val),
        .resp_rdy  (resp_rdy),
        .resp_diff (resp_diff),
        .resp_bout (resp_bout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic bi,
                         input logic [7:0] exp_d, input logic exp_b, input int stall);
        int wait_c;
        int lat;
        wait_c = 0;
        while (!req_rdy && wait_c < 30) begin
            tick();
            wait_c++;
        end
        check("req_rdy_idle", {31'd0, req_rdy}, 32'd1);
        req_val  = 1'b1;
        req_in0  = a;
        req_in1  = b;
        req_bin  = bi;
        resp_rdy = (stall == 0);
        tick();
        check("req_rdy_busy", {31'd0, req_rdy}, 32'd0);
        // Garbage request held during CALC must be ignored.
        req_in0 = ~a;
        req_in1 = a;
        req_bin = ~bi;
        lat = 0;
        while (!resp_val && lat < 20) begin
            tick();
            lat++;
        end
        check("latency", lat, 32'd8);
        check("diff", {24'd0, resp_diff}, {24'd0, exp_d});
        check("bout", {31'd0, resp_bout}, {31'd0, exp_b});
        for (int s = 0; s < stall; s++) begin
            req_val = 1'b1;
            req_in0 = 8'($urandom);
            req_in1 = 8'($urandom);
            tick();
            check("hold_resp_val", {31'd0, resp_val}, 32'd1);
            check("hold_req_rdy", {31'd0, req_rdy}, 32'd0);
            check("hold_diff", {24'd0, resp_diff}, {24'd0, exp_d});
            check("hold_bout", {31'd0, resp_bout}, {31'd0, exp_b});
        end
        req_val  = 1'b0;
        resp_rdy = 1'b1;
        tick();
        resp_rdy = 1'b0;
        check("req_rdy_after", {31'd0, req_rdy}, 32'd1);
        check("resp_val_after", {31'd0, resp_val}, 32'd0);
    endtask

    initial begin
        logic [8:0] gold;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rbi;

        reset    = 1'b0;
        req_val  = 1'b0;
        req_in0  = 8'h00;
        req_in1  = 8'h00;
        req_bin  = 1'b0;
        resp_rdy = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        check("rst_req_rdy", {31'd0, req_rdy}, 32'd1);
        check("rst_resp_val", {31'd0, resp_val}, 32'd0);
        check("rst_diff", {24'd0, resp_diff}, 32'd0);
        check("rst_bout", {31'd0, resp_bout}, 32'd0);

        do_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 0);
        do_op(8'h05, 8'h03, 1'b1, 8'h01, 1'b0, 0);
        do_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 0);
        do_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 0);
        do_op(8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 0);
        do_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0);
        do_op(8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 5);

        // Reset asserted on the 4th CALC edge aborts the operation.
        req_val = 1'b1;
        req_in0 = 8'h12;
        req_in1 = 8'h34;
        req_bin = 1'b1;
        tick();
        req_val = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("abort_req_rdy", {31'd0, req_rdy}, 32'd1);
        check("abort_resp_val", {31'd0, resp_val}, 32'd0);
        check("abort_diff", {24'd0, resp_diff}, 32'd0);
        check("abort_bout", {31'd0, resp_bout}, 32'd0);
        tick();
        check("abort_no_resp", {31'd0, resp_val}, 32'd0);
        do_op(8'h40, 8'h3F, 1'b0, 8'h01, 1'b0, 0);

        for (int i = 0; i < 20; i++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rbi  = 1'($urandom);
            gold = {1'b0, ra} - {1'b0, rb} - {8'd0, rbi};
            do_op(ra, rb, rbi, gold[7:0], gold[8], int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
